lp_sol_streamer: RTL and testbench

- Downstream consumer of the simplex solver.
- Detects the rising edge of the solver's done level and snapshots the full solution vector and the LB/UB bound vectors, which the solver does not apply.
- Streams the first ncoef entries out over a valid/ready interface, one per beat. Each beat is checked against its bounds and optionally clamped.
- Sits between the LP solver and the result consumer (host readback / controller).

---
 rtl/lp_sol_streamer_pkg.sv | 25 ++
 rtl/lp_sol_streamer_if.sv | 29 ++
 rtl/lp_sol_streamer_fp32_cmp.sv | 24 ++
 rtl/lp_sol_streamer.sv | 116 +++++++++++
 tb/tb_lp_sol_streamer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/lp_sol_streamer_pkg.sv
// +----------------------------------------------------------------------------+
// | lp_pkg : shared types and fp32 ordering helpers for lp_sol_streamer          |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

package lp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [31:0] FP32_ONE = 32'h3F80_0000;

  // Map an fp32 bit pattern onto an unsigned key whose integer order matches
  // the float order (-0 sorts just below +0; NaNs land at the extremes).
  function automatic logic [31:0] fp32_key(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lp_sol_streamer_if.sv
// +----------------------------------------------------------------------------+
// | lp_sol_streamer_if : valid/ready output stream of the solution streamer      |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

interface lp_sol_streamer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NCOEFMAX   = 512
);
  logic                        m_valid_o;
  logic                        m_ready_i;
  logic [DATA_WIDTH-1:0]       m_data_o;
  logic [$clog2(NCOEFMAX)-1:0] m_index_o;
  logic                        m_last_o;
  logic                        m_viol_o;

  modport master (
    output m_valid_o, m_data_o, m_index_o, m_last_o, m_viol_o,
    input  m_ready_i
  );

  modport slave (
    input  m_valid_o, m_data_o, m_index_o, m_last_o, m_viol_o,
    output m_ready_i
  );
endinterface

`default_nettype wire

// File: rtl/lp_sol_streamer_fp32_cmp.sv
// +----------------------------------------------------------------------------+
// | fp32_cmp : combinational total-order compare of two fp32 bit patterns        |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module fp32_cmp
  import lp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        lt,
  output logic        gt
);
  logic [31:0] key_a;
  logic [31:0] key_b;

  assign key_a = fp32_key(a);
  assign key_b = fp32_key(b);
  assign lt    = key_a < key_b;
  assign gt    = key_a > key_b;
endmodule

`default_nettype wire

// File: rtl/lp_sol_streamer.sv
// +----------------------------------------------------------------------------+
// | lp_sol_streamer : snapshots the solver result on done and streams it out    |
// | with per-beat bound checking and optional clamping.  Revision: 1.0          |
// +----------------------------------------------------------------------------+
`default_nettype none

module lp_sol_streamer
  import lp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NCOEFMAX   = 512
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 done_i,
  input  logic [NCOEFMAX-1:0][DATA_WIDTH-1:0]  sol_i,
  input  logic [NCOEFMAX-1:0][DATA_WIDTH-1:0]  LB_i,
  input  logic [NCOEFMAX-1:0][DATA_WIDTH-1:0]  UB_i,
  input  logic [$clog2(NCOEFMAX):0]            ncoef_i,
  input  logic                                 clamp_en_i,
  lp_sol_streamer_if.master                    m,
  output logic                                 busy_o,
  output logic [$clog2(NCOEFMAX):0]            viol_count_o,
  output logic                                 frame_done_o
);
  localparam int IW = $clog2(NCOEFMAX);
  localparam int NW = IW + 1;
  localparam logic [NW-1:0] N_MAX = NW'(NCOEFMAX);

  state_t                               state, state_nxt;
  logic                                 done_q;
  logic [NCOEFMAX-1:0][DATA_WIDTH-1:0]  snap_sol, snap_lb, snap_ub;
  logic                                 clamp_q;
  logic [NW-1:0]                        n_q, n_in;
  logic [IW-1:0]                        idx;
  logic                                 start, load, valid, last;
  logic [DATA_WIDTH-1:0]                x, lb, ub;
  logic                                 below, above, lb_gt_unused, ub_lt_unused;

  assign start = done_i & ~done_q;
  assign n_in  = (ncoef_i > N_MAX) ? N_MAX : ncoef_i;

  assign x    = snap_sol[idx];
  assign lb   = snap_lb[idx];
  assign ub   = snap_ub[idx];
  assign last = ({1'b0, idx} == (n_q - NW'(1)));

  fp32_cmp u_cmp_lb (.a(x), .b(lb), .lt(below),        .gt(lb_gt_unused));
  fp32_cmp u_cmp_ub (.a(x), .b(ub), .lt(ub_lt_unused), .gt(above));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= IDLE;
      done_q       <= 1'b0;
      snap_sol     <= '0;
      snap_lb      <= '0;
      snap_ub      <= '0;
      clamp_q      <= 1'b0;
      n_q          <= '0;
      idx          <= '0;
      viol_count_o <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= done_i;
      if (load) begin
        snap_sol     <= sol_i;
        snap_lb      <= LB_i;
        snap_ub      <= UB_i;
        clamp_q      <= clamp_en_i;
        n_q          <= n_in;
        idx          <= '0;
        viol_count_o <= '0;
      end else if (valid && m.m_ready_i) begin
        viol_count_o <= viol_count_o + NW'(m.m_viol_o);
        if (!last) idx <= idx + IW'(1);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    valid        = 1'b0;
    busy_o       = 1'b0;
    frame_done_o = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = (n_in == '0) ? FINISH : STREAM;
        end
      end
      STREAM: begin
        valid  = 1'b1;
        busy_o = 1'b1;
        if (m.m_ready_i && last) state_nxt = FINISH;
      end
      FINISH: begin
        frame_done_o = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced to zero outside STREAM; below wins when LB > UB.
  assign m.m_valid_o = valid;
  assign m.m_index_o = valid ? idx : '0;
  assign m.m_last_o  = valid & last;
  assign m.m_viol_o  = valid & (below | above);
  assign m.m_data_o  = !valid            ? '0 :
                       (clamp_q & below) ? lb :
                       (clamp_q & above) ? ub : x;
endmodule

`default_nettype wire

// File: tb/tb_lp_sol_streamer.sv
// +----------------------------------------------------------------------------+
// | tb_lp_sol_streamer : directed self-checking bench for lp_sol_streamer       |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_lp_sol_streamer;
  import lp_pkg::*;

  localparam int DW = 32;
  localparam int NM = 8;

  logic              clk;
  logic              rstn;
  logic              done;
  logic [NM-1:0][DW-1:0] sol, lbv, ubv;
  logic [3:0]        ncoef;
  logic              clamp_en;
  logic              busy;
  logic [3:0]        viol_count;
  logic              frame_done;

  int checks = 0;
  int errors = 0;
  int beats;
  int last_idx;
  int spurious;

  lp_sol_streamer_if #(.DATA_WIDTH(DW), .NCOEFMAX(NM)) mif ();

  lp_sol_streamer #(.DATA_WIDTH(DW), .NCOEFMAX(NM)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .done_i       (done),
    .sol_i        (sol),
    .LB_i         (lbv),
    .UB_i         (ubv),
    .ncoef_i      (ncoef),
    .clamp_en_i   (clamp_en),
    .m            (mif.master),
    .busy_o       (busy),
    .viol_count_o (viol_count),
    .frame_done_o (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge right after the start edge.
  task automatic start_frame();
    done = 1'b0;
    tick();
    done = 1'b1;
    tick();
  endtask

  task automatic beat(input string tag, input logic [31:0] data, input logic [2:0] index,
                      input logic lst, input logic viol);
    chk({tag, "_valid"}, 64'(mif.m_valid_o), 64'd1);
    chk({tag, "_data"},  64'(mif.m_data_o),  64'(data));
    chk({tag, "_index"}, 64'(mif.m_index_o), 64'(index));
    chk({tag, "_last"},  64'(mif.m_last_o),  64'(lst));
    chk({tag, "_viol"},  64'(mif.m_viol_o),  64'(viol));
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_valid"}, 64'(mif.m_valid_o), 64'd0);
    chk({tag, "_data"},  64'(mif.m_data_o),  64'd0);
    chk({tag, "_index"}, 64'(mif.m_index_o), 64'd0);
    chk({tag, "_last"},  64'(mif.m_last_o),  64'd0);
    chk({tag, "_viol"},  64'(mif.m_viol_o),  64'd0);
    chk({tag, "_busy"},  64'(busy),          64'd0);
    chk({tag, "_vcnt"},  64'(viol_count),    64'd0);
    chk({tag, "_fdone"}, 64'(frame_done),    64'd0);
  endtask

  initial begin
    rstn = 1'b0; done = 1'b0; sol = '0; lbv = '0; ubv = '0;
    ncoef = '0; clamp_en = 1'b0; mif.m_ready_i = 1'b0;
    #1;
    all_zero("reset");
    tick(); tick();
    rstn = 1'b1;
    tick();

    // 1: plain in-bound frame of three beats
    sol[0] = FP32_ONE;      sol[1] = 32'h4000_0000; sol[2] = 32'h4040_0000;
    ubv[0] = 32'h4120_0000; ubv[1] = 32'h4120_0000; ubv[2] = 32'h4120_0000;
    ncoef = 4'd3; mif.m_ready_i = 1'b1;
    start_frame();
    beat("t1_b0", FP32_ONE, 3'd0, 1'b0, 1'b0);
    chk("t1_busy", 64'(busy), 64'd1);
    tick(); beat("t1_b1", 32'h4000_0000, 3'd1, 1'b0, 1'b0);
    tick(); beat("t1_b2", 32'h4040_0000, 3'd2, 1'b1, 1'b0);
    tick();
    chk("t1_fin_valid", 64'(mif.m_valid_o), 64'd0);
    chk("t1_fin_fdone", 64'(frame_done), 64'd1);
    chk("t1_fin_busy",  64'(busy), 64'd0);
    tick();
    chk("t1_fdone_pulse", 64'(frame_done), 64'd0);
    chk("t1_vcnt", 64'(viol_count), 64'd0);

    // 2: clamping, with inputs disturbed after capture
    sol = '0; lbv = '0; ubv = '0;
    sol[0] = 32'hBF80_0000; ubv[0] = 32'h4120_0000;
    sol[1] = 32'h4140_0000; ubv[1] = 32'h4120_0000;
    ncoef = 4'd2; clamp_en = 1'b1;
    start_frame();
    clamp_en = 1'b0; sol[1] = FP32_ONE; ncoef = 4'd5;
    beat("t2_c_b0", 32'h0000_0000, 3'd0, 1'b0, 1'b1);
    tick(); beat("t2_c_b1", 32'h4120_0000, 3'd1, 1'b1, 1'b1);
    tick();
    chk("t2_c_fdone", 64'(frame_done), 64'd1);
    chk("t2_c_vcnt",  64'(viol_count), 64'd2);
    tick(); tick();
    chk("t2_vcnt_hold", 64'(viol_count), 64'd2);
    sol[1] = 32'h4140_0000; ncoef = 4'd2; clamp_en = 1'b0;
    start_frame();
    beat("t2_r_b0", 32'hBF80_0000, 3'd0, 1'b0, 1'b1);
    tick(); beat("t2_r_b1", 32'h4140_0000, 3'd1, 1'b1, 1'b1);
    tick();
    chk("t2_r_vcnt", 64'(viol_count), 64'd2);

    // 3: backpressure, ready pattern 0,0,1,0,1
    sol = '0; lbv = '0; ubv = '0;
    sol[0] = FP32_ONE; sol[1] = 32'h4000_0000;
    ubv[0] = 32'h4120_0000; ubv[1] = 32'h4120_0000;
    ncoef = 4'd2; mif.m_ready_i = 1'b0;
    start_frame();
    beat("t3_s0", FP32_ONE, 3'd0, 1'b0, 1'b0);
    tick(); beat("t3_s1", FP32_ONE, 3'd0, 1'b0, 1'b0);
    tick(); beat("t3_s2", FP32_ONE, 3'd0, 1'b0, 1'b0);
    mif.m_ready_i = 1'b1;
    tick(); beat("t3_s3", 32'h4000_0000, 3'd1, 1'b1, 1'b0);
    mif.m_ready_i = 1'b0;
    tick(); beat("t3_s4", 32'h4000_0000, 3'd1, 1'b1, 1'b0);
    chk("t3_s4_fdone", 64'(frame_done), 64'd0);
    mif.m_ready_i = 1'b1;
    tick();
    chk("t3_fdone", 64'(frame_done), 64'd1);
    chk("t3_valid", 64'(mif.m_valid_o), 64'd0);

    // 4: empty frame, then held-high done must not retrigger
    ncoef = 4'd0;
    start_frame();
    chk("t4_valid", 64'(mif.m_valid_o), 64'd1 - 64'd1);
    chk("t4_fdone", 64'(frame_done), 64'd1);
    ncoef = 4'd1;
    spurious = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mif.m_valid_o || frame_done) spurious++;
    end
    chk("t4_no_retrigger", 64'(spurious), 64'd0);
    start_frame();
    beat("t4_new", FP32_ONE, 3'd0, 1'b1, 1'b0);
    tick();
    chk("t4_new_fdone", 64'(frame_done), 64'd1);

    // 5: asynchronous reset in the middle of an 8-beat frame
    for (int i = 0; i < NM; i++) begin
      sol[i] = 32'h4140_0000; lbv[i] = '0; ubv[i] = 32'h4120_0000;
    end
    ncoef = 4'd8;
    start_frame();
    for (int i = 0; i < 5; i++) tick();
    beat("t5_mid", 32'h4140_0000, 3'd5, 1'b0, 1'b1);
    chk("t5_mid_vcnt", 64'(viol_count), 64'd5);
    done = 1'b0;
    rstn = 1'b0;
    #1;
    all_zero("t5_rst");
    tick(); tick();
    rstn = 1'b1;
    spurious = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (mif.m_valid_o || frame_done) spurious++;
    end
    chk("t5_idle_after_rst", 64'(spurious), 64'd0);
    start_frame();
    beat("t5_restart", 32'h4140_0000, 3'd0, 1'b0, 1'b1);
    chk("t5_restart_vcnt", 64'(viol_count), 64'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("t5_fdone", 64'(frame_done), 64'd1);
    chk("t5_vcnt", 64'(viol_count), 64'd8);

    // 6: signed zero, negative range, and LB > UB priority
    sol = '0; lbv = '0; ubv = '0;
    sol[0] = 32'h8000_0000; ubv[0] = 32'h4120_0000;
    sol[1] = 32'hC000_0000; lbv[1] = 32'hC040_0000; ubv[1] = 32'hBF80_0000;
    sol[2] = 32'h4000_0000; lbv[2] = 32'h4040_0000; ubv[2] = FP32_ONE;
    ncoef = 4'd3; clamp_en = 1'b1;
    start_frame();
    beat("t6_negzero", 32'h0000_0000, 3'd0, 1'b0, 1'b1);
    tick(); beat("t6_negrange", 32'hC000_0000, 3'd1, 1'b0, 1'b0);
    tick(); beat("t6_lb_gt_ub", 32'h4040_0000, 3'd2, 1'b1, 1'b1);
    tick();
    chk("t6_vcnt", 64'(viol_count), 64'd2);

    // 7: ncoef above NCOEFMAX saturates to NCOEFMAX beats
    for (int i = 0; i < NM; i++) begin
      sol[i] = FP32_ONE; lbv[i] = '0; ubv[i] = 32'h4120_0000;
    end
    ncoef = 4'd15; clamp_en = 1'b0;
    start_frame();
    beats = 0; last_idx = -1;
    for (int c = 0; c < 20 && !frame_done; c++) begin
      if (mif.m_valid_o) begin
        chk("t7_order", 64'(mif.m_index_o), 64'(beats));
        if (mif.m_last_o) last_idx = int'(mif.m_index_o);
        beats++;
      end
      tick();
    end
    chk("t7_beats", 64'(beats), 64'd8);
    chk("t7_last_idx", 64'(last_idx), 64'd7);
    chk("t7_fdone", 64'(frame_done), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
